// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive path.
// Combinational helpers only; no latency, no backpressure.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int N_CH_DEF = 4;
  localparam int DW_DEF   = 8;

  function automatic int last_slot(input int n_ch);
    return n_ch - 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter that wraps explicitly after the last slot.
// Updates one cycle after a control strobe; holds when no strobe (no backpressure).
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          last
);

  localparam logic [SW-1:0] LAST_IDX = SW'(last_slot(N_CH));

  assign last = (slot == LAST_IDX);

  // clr beats load1 beats adv; wrap is explicit so odd N_CH never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (adv) begin
      slot <= last ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demux: aligns to sync, gathers N_CH words, publishes a coherent frame (TDM_FRAME_CNT_EN adds frame_cnt/cnt_clr).
// Latency 1 clk from last-slot sample to dout/frame_valid; en low holds all state (no backpressure).
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  parameter  int DW   = DW_DEF,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic [DW-1:0]      din,
  output logic [N_CH*DW-1:0] dout,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               locked,
  output logic [SW-1:0]      slot
`ifdef TDM_FRAME_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [15:0]        frame_cnt
`endif
);

  state_e              state, state_d;
  logic                adv, load1, clr, last;
  logic                wr_en, pub, err;
  logic [SW-1:0]       wr_idx;
  logic [DW-1:0]       shadow [N_CH-1];
  logic [N_CH*DW-1:0]  pub_word;

  tdm_slot_ctr #(.N_CH(N_CH)) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .load1 (load1),
    .clr   (clr),
    .slot  (slot),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    adv     = 1'b0;
    load1   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = slot;
    pub     = 1'b0;
    err     = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            load1   = 1'b1;
            state_d = LOCK;
          end
        end
        default: begin
          if (slot == '0) begin
            if (sync) begin
              wr_en  = 1'b1;
              wr_idx = '0;
              load1  = 1'b1;
            end else begin
              err     = 1'b1;
              clr     = 1'b1;
              state_d = HUNT;
            end
          end else if (sync) begin
            // early sync: restart the frame on this word, drop what was gathered
            err    = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
            load1  = 1'b1;
          end else begin
            wr_en = !last;
            adv   = 1'b1;
            pub   = last;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH - 1; k++) shadow[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_CH - 1; k++) begin
        if (wr_idx == SW'(k)) shadow[k] <= din;
      end
    end
  end

  // last slot goes straight from din so the whole frame lands in one edge
  always_comb begin
    pub_word = '0;
    for (int k = 0; k < N_CH - 1; k++) pub_word[k*DW +: DW] = shadow[k];
    pub_word[(N_CH-1)*DW +: DW] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= pub;
      frame_err   <= err;
      if (pub) dout <= pub_word;
    end
  end

  assign locked = (state == LOCK);

`ifdef TDM_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (cnt_clr) begin
      frame_cnt <= '0;
    end else if (pub) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: frame-level reference model checked every cycle plus literal frame checks.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              sync = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [N*DW-1:0]   dout;
  logic              frame_valid, frame_err, locked;
  logic [SW-1:0]     slot;
`ifdef TDM_FRAME_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [15:0]       frame_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  tdm_demux #(.N_CH(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .dout        (dout),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked),
    .slot        (slot)
`ifdef TDM_FRAME_CNT_EN
    ,
    .cnt_clr     (cnt_clr),
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks frame alignment with plain ints and a word array
  bit            m_locked;
  int            m_slot;
  logic [DW-1:0] m_buf [N];
  logic [N*DW-1:0] m_dout;
  bit            m_fv, m_fe;

  function automatic logic [N*DW-1:0] frame_of(input logic [DW-1:0] last_word);
    logic [N*DW-1:0] f;
    for (int i = 0; i < N - 1; i++) f[i*DW +: DW] = m_buf[i];
    f[(N-1)*DW +: DW] = last_word;
    return f;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked <= 1'b0;
      m_slot   <= 0;
      m_dout   <= '0;
      m_fv     <= 1'b0;
      m_fe     <= 1'b0;
      for (int i = 0; i < N; i++) m_buf[i] <= '0;
    end else begin
      m_fv <= 1'b0;
      m_fe <= 1'b0;
      if (en) begin
        if (!m_locked) begin
          if (sync) begin
            m_buf[0] <= din; m_slot <= 1; m_locked <= 1'b1;
          end
        end else if (m_slot == 0) begin
          if (sync) begin
            m_buf[0] <= din; m_slot <= 1;
          end else begin
            m_fe <= 1'b1; m_locked <= 1'b0;
          end
        end else if (sync) begin
          m_fe <= 1'b1; m_buf[0] <= din; m_slot <= 1;
        end else if (m_slot == N - 1) begin
          m_dout <= frame_of(din); m_fv <= 1'b1; m_slot <= 0;
        end else begin
          m_buf[m_slot] <= din; m_slot <= m_slot + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_dout", dout, m_dout);
      chk("cyc_frame_valid", frame_valid, m_fv);
      chk("cyc_frame_err", frame_err, m_fe);
      chk("cyc_locked", locked, m_locked);
      chk("cyc_slot", slot, m_slot);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    en = 1'b1; din = d; sync = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; sync = 1'b0;
    end
  endtask

  task automatic frame(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                       input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    send(b0, 1'b1); send(b1, 1'b0); send(b2, 1'b0); send(b3, 1'b0);
    idle(1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slot", slot, 0);
    chk("rst_fv", frame_valid, 0);
    rst = 1'b0;
    run = 1'b1;

    // lock and publish
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("lock_dout", dout, 32'h44332211);
    chk("lock_fv", frame_valid, 1);
    chk("lock_locked", locked, 1);
    idle(1);
    chk("lock_fv_pulse", frame_valid, 0);

    // missing sync on slot 0
    send(8'h99, 1'b0);
    idle(1);
    chk("miss_err", frame_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_dout", dout, 32'h44332211);

    // hunt discard then a good frame
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    idle(1);
    chk("hunt_err", frame_err, 0);
    chk("hunt_slot", slot, 0);
    frame(8'h01, 8'h02, 8'h03, 8'h04);
    chk("hunt_dout", dout, 32'h04030201);
    chk("hunt_fv", frame_valid, 1);

    // enable gaps between every slot
    send(8'h11, 1'b1); idle(1);
    chk("gap_slot_a", slot, 1);
    idle(2);
    chk("gap_slot_b", slot, 1);
    send(8'h22, 1'b0); idle(3);
    send(8'h33, 1'b0); idle(3);
    chk("gap_no_fv", frame_valid, 0);
    chk("gap_slot_c", slot, 3);
    send(8'h44, 1'b0); idle(1);
    chk("gap_dout", dout, 32'h44332211);
    chk("gap_fv", frame_valid, 1);
    idle(2);

    // early sync
    send(8'h11, 1'b1); send(8'h22, 1'b0); send(8'h55, 1'b1);
    idle(1);
    chk("early_err", frame_err, 1);
    chk("early_locked", locked, 1);
    chk("early_slot", slot, 1);
    chk("early_dout_hold", dout, 32'h44332211);
    send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    idle(1);
    chk("early_dout", dout, 32'h88776655);

    // async reset mid-frame
    send(8'h01, 1'b1); send(8'h02, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_locked", locked, 0);
    chk("arst_slot", slot, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h03, 1'b0); send(8'h04, 1'b0);
    idle(1);
    chk("arst_no_fv", frame_valid, 0);
    chk("arst_dout_zero", dout, 0);
    frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    chk("arst_new_dout", dout, 32'hA4A3A2A1);
    chk("arst_new_fv", frame_valid, 1);

`ifdef TDM_FRAME_CNT_EN
    frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    idle(1);
    chk("cnt_three", frame_cnt, 3);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr", frame_cnt, 0);
`endif

    idle(3);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of a time-division-multiplexed link whose transmitter selects one channel per slot through an enabled mux.
- Takes one DW-bit word per enabled clock, uses a frame sync marker to align to slot 0, and writes each word into its channel's shadow register.
- Publishes a complete, coherent frame of N_CH channels with a one-cycle valid pulse.
- Detects sync errors and re-hunts for alignment.

Parameters:
- N_CH, 4, channels per frame (slots), >=2
- DW, 8, bits per channel word
- SW, $clog2(N_CH), slot counter width (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  slot strobe; input sampled only when high; low = hold everything
- sync  in  1  marks the current word as slot 0; qualified by en
- din  in  DW  slot data
- dout  out  N_CH*DW  published frame; channel k at bits [k*DW +: DW]
- frame_valid  out  1  one-cycle pulse; dout just updated
- frame_err  out  1  one-cycle pulse on sync error
- locked  out  1  high while in LOCK state
- slot  out  SW  next expected slot index

Behaviour:
- Reset (async, immediate): state=HUNT, slot=0, dout=0, shadow=0, frame_valid=0, frame_err=0, locked=0.
- When en=0: no state, slot or shadow change. frame_valid and frame_err are driven 0.
- HUNT state:
  - en&&!sync: word discarded, slot stays 0.
  - en&&sync: shadow[0]<=din, slot<=1, state<=LOCK.
- LOCK state, on en:
  - slot==0 && sync: shadow[0]<=din, slot<=1.
  - slot==0 && !sync (missing sync): frame_err pulse, word discarded, state<=HUNT, slot<=0.
  - slot!=0 && !sync: shadow[slot]<=din, slot<=slot+1 (wraps to 0 after N_CH-1).
  - slot!=0 && sync (early sync): frame_err pulse, partial frame discarded (no publish), shadow[0]<=din, slot<=1, stays LOCK.
- Publish: in the cycle that writes slot N_CH-1, dout<={din, shadow[N_CH-2:0]} registered. frame_valid=1 on the next cycle edge, i.e. same cycle dout changes. Latency is 1 clk from the last-slot sample to dout/frame_valid.
- dout holds between publishes. Partial frames never reach dout.
- locked = (state==LOCK), registered.
- frame_err and frame_valid are mutually exclusive by construction.
- slot uses SW bits. Non-power-of-two N_CH wraps explicitly at N_CH-1, never via overflow.
- Reset asserted mid-frame: all in-flight data lost; the first sync after release starts a new frame.

Optional Feature:
- Macro: TDM_FRAME_CNT_EN.
- Defined: adds output frame_cnt out 16 and input cnt_clr in 1.
  - frame_cnt increments on each frame_valid and wraps 0xFFFF->0. Resets to 0.
  - cnt_clr is synchronous, and it has priority over an increment in the same cycle.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package tdm_pkg:
  - state enum {HUNT, LOCK}
  - default N_CH/DW constants
  - function for the last-slot index
- Sub-module tdm_slot_ctr:
  - wrap-at-N_CH slot counter
  - inputs: clk, rst, adv, load1, clr
  - output: slot; last flag combinational
- The top holds the FSM, the shadow registers and the publish register.

Test Plan:
- Lock and publish: N_CH=4, DW=8, en=1. Words 0x11(sync),0x22,0x33,0x44 -> next cycle dout=0x44332211, frame_valid=1 for exactly 1 cycle, locked=1.
- Hunt discard: 0xAA,0xBB without sync, then a valid frame 0x01(sync)..0x04 -> dout=0x04030201. No frame_err while in HUNT.
- Enable gaps: same frame with en=0 for 3 cycles between each slot -> identical dout. slot is frozen during the gaps. frame_valid fires only after 0x44.
- Early sync: 0x11(sync),0x22, then 0x55(sync),0x66,0x77,0x88 -> frame_err pulse on the 0x55 cycle, dout=0x88776655, old partial never published.
- Missing sync: after a good frame, the next slot-0 word 0x99 arrives without sync -> frame_err=1, locked=0 next cycle, dout unchanged.
- Async reset mid-frame: assert rst between slots 1 and 2 -> outputs zero without a clock edge. Post-release a full frame is needed for frame_valid. With TDM_FRAME_CNT_EN, 3 good frames -> frame_cnt=3, cnt_clr -> 0.
